// File: rtl/config_table_bank.sv
// Config table bank: framed AXI-Stream burst loader with per-entry valid bits and
// NUM_RD independent registered read ports (read-first, BRAM/URAM-friendly array).
module config_table_bank #(
    parameter int unsigned DWIDTH = 512,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = 6,
    parameter int unsigned NUM_RD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic [AW-1:0]            load_base,
    input  logic                     clear,
    input  logic [DWIDTH-1:0]        s_axis_tdata,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     busy,
    output logic                     load_done,
    output logic [AW:0]              load_count,
    output logic                     ovf_err,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*AW-1:0]     rd_add,
    output logic [NUM_RD*DWIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_vld,
    output logic [NUM_RD-1:0]        rd_hit
);

    localparam logic [AW:0]   DepthW   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

    state_e            state_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW:0]       load_count_q;
    logic              ovf_q;
    logic [DEPTH-1:0]  valid_q;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic              beat_acc;
    logic              mem_we;

    // clear kills the handshake combinationally so no beat slips in on that cycle
    assign s_axis_tready = ((state_q == StLoad) || (state_q == StDrain)) && !clear;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign mem_we        = rst_n && beat_acc && (state_q == StLoad);
    assign busy          = (state_q == StLoad) || (state_q == StDrain);
    assign load_done     = (state_q == StDone);
    assign load_count    = load_count_q;
    assign ovf_err       = ovf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            ovf_q        <= 1'b0;
            valid_q      <= '0;
        end else if (clear) begin
            state_q <= StIdle;
            ovf_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load_start) begin
                        wr_ptr_q     <= load_base;
                        load_count_q <= '0;
                        if ({1'b0, load_base} >= DepthW) begin
                            ovf_q   <= 1'b1;
                            state_q <= StDrain;
                        end else begin
                            ovf_q   <= 1'b0;
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (beat_acc) begin
                        valid_q[wr_ptr_q] <= 1'b1;
                        load_count_q      <= load_count_q + (AW+1)'(1);
                        wr_ptr_q          <= wr_ptr_q + AW'(1);
                        if (s_axis_tlast) begin
                            state_q <= StDone;
                        end else if (wr_ptr_q == LastAddr) begin
                            // no wrap-around: remaining beats are swallowed
                            ovf_q   <= 1'b1;
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (beat_acc && s_axis_tlast) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= s_axis_tdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic              hit;
        logic [DWIDTH-1:0] raw_q;
        logic              hit_q;
        logic              vld_q;

        assign addr = rd_add[k*AW +: AW];
        assign hit  = ({1'b0, addr} < DepthW) && valid_q[addr];

        // unreset raw read register keeps the array mappable to block RAM
        always_ff @(posedge clk) begin
            if (rd_en[k]) begin
                raw_q <= mem[addr];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                hit_q <= 1'b0;
            end else begin
                vld_q <= rd_en[k];
                if (rd_en[k]) begin
                    hit_q <= hit;
                end
            end
        end

        assign rd_data[k*DWIDTH +: DWIDTH] = hit_q ? raw_q : '0;
        assign rd_vld[k]                   = vld_q;
        assign rd_hit[k]                   = hit_q;
    end

endmodule

// File: tb/tb_config_table_bank.sv
// Self-checking bench for config_table_bank: directed load scenarios with randomized
// beat gaps, data and read traffic, checked against an entry-level model of the table.
module tb_config_table_bank;

    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 60;
    localparam int unsigned AW    = 6;
    localparam int unsigned NR    = 4;

    logic              clk;
    logic              rst_n;
    logic              load_start;
    logic [AW-1:0]     load_base;
    logic              clear;
    logic [DW-1:0]     s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tlast;
    logic              s_axis_tready;
    logic              busy;
    logic              load_done;
    logic [AW:0]       load_count;
    logic              ovf_err;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_add;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_vld;
    logic [NR-1:0]     rd_hit;

    config_table_bank #(
        .DWIDTH (DW),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .NUM_RD (NR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_base     (load_base),
        .clear         (clear),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .busy          (busy),
        .load_done     (load_done),
        .load_count    (load_count),
        .ovf_err       (ovf_err),
        .rd_en         (rd_en),
        .rd_add        (rd_add),
        .rd_data       (rd_data),
        .rd_vld        (rd_vld),
        .rd_hit        (rd_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table model: contents and valid flag per address, plus held read-port results.
    logic [DW-1:0] m_mem   [64];
    bit            m_valid [64];
    logic [DW-1:0] e_data  [NR];
    bit            e_hit   [NR];

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    task automatic rand_reads();
        rd_en = NR'($urandom);
        for (int k = 0; k < NR; k++) rd_add[k*AW +: AW] = AW'($urandom_range(0, 63));
    endtask

    // One clock: predicts reads from pre-edge model, then applies this cycle's write/clear.
    task automatic tick(input bit wr, input int waddr, input logic [DW-1:0] wdata, input bit clr);
        logic [NR-1:0] ev;
        ev = rd_en;
        for (int k = 0; k < NR; k++) begin
            if (rd_en[k]) begin
                int a;
                a = int'(rd_add[k*AW +: AW]);
                if (a < int'(DEPTH) && m_valid[a]) begin
                    e_hit[k]  = 1'b1;
                    e_data[k] = m_mem[a];
                end else begin
                    e_hit[k]  = 1'b0;
                    e_data[k] = '0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (clr) begin
            for (int a = 0; a < 64; a++) m_valid[a] = 1'b0;
        end else if (wr && waddr < int'(DEPTH)) begin
            m_mem[waddr]   = wdata;
            m_valid[waddr] = 1'b1;
        end
        chk("rd_vld", 64'(rd_vld), 64'(ev));
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("rd_hit[%0d]", k), 64'(rd_hit[k]), 64'(e_hit[k]));
            chk($sformatf("rd_data[%0d]", k), rd_data[k*DW +: DW], e_data[k]);
        end
        rand_reads();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rd_en = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 64; a++) m_valid[a] = 1'b0;
        for (int k = 0; k < NR; k++) begin
            e_hit[k]  = 1'b0;
            e_data[k] = '0;
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_count", 64'(load_count), 64'd0);
        chk("rst_ovf", 64'(ovf_err), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_rd_vld", 64'(rd_vld), 64'd0);
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);
        chk("rst_rd_data", 64'(rd_data != '0), 64'd0);
    endtask

    task automatic sweep();
        for (int a = 0; a < 64; a += NR) begin
            rd_en = '1;
            for (int k = 0; k < NR; k++) rd_add[k*AW +: AW] = AW'(a + k);
            tick(1'b0, 0, '0, 1'b0);
        end
    endtask

    task automatic start_load(input int base);
        load_start = 1'b1;
        load_base  = AW'(base);
        tick(1'b0, 0, '0, 1'b0);
        load_start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_count", 64'(load_count), 64'd0);
        chk("start_ovf", 64'(ovf_err), 64'(base >= int'(DEPTH)));
    endtask

    // Full burst of n beats with random tvalid gaps; port 0 always snoops the target entry.
    task automatic burst(input int base, input int n);
        int  i;
        int  cyc;
        int  exp_cnt;
        bit  acc;
        start_load(base);
        i   = 0;
        cyc = 0;
        while (i < n) begin
            if (cyc > 2000) begin
                chk("burst_timeout", 64'(i), 64'(n));
                break;
            end
            s_axis_tvalid = ($urandom_range(0, 2) != 0);
            s_axis_tdata  = rand_word();
            s_axis_tlast  = (i == n - 1);
            rd_en[0]          = 1'b1;
            rd_add[0 +: AW]   = AW'(base + i);
            #1;
            chk("burst_tready", 64'(s_axis_tready), 64'd1);
            acc = s_axis_tvalid;
            tick(acc, base + i, s_axis_tdata, 1'b0);
            if (acc) i++;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        exp_cnt = 0;
        for (int j = 0; j < n; j++) if (base + j < int'(DEPTH)) exp_cnt++;
        chk("done_pulse", 64'(load_done), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_tready", 64'(s_axis_tready), 64'd0);
        chk("done_count", 64'(load_count), 64'(exp_cnt));
        chk("done_ovf", 64'(ovf_err), 64'(base + n > int'(DEPTH)));
        tick(1'b0, 0, '0, 1'b0);
        chk("done_single", 64'(load_done), 64'd0);
        chk("hold_count", 64'(load_count), 64'(exp_cnt));
        chk("hold_ovf", 64'(ovf_err), 64'(base + n > int'(DEPTH)));
    endtask

    task automatic clear_mid(input int base);
        start_load(base);
        for (int i = 0; i < 2; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rand_word();
            s_axis_tlast  = 1'b0;
            #1;
            chk("clr_pre_tready", 64'(s_axis_tready), 64'd1);
            tick(1'b1, base + i, s_axis_tdata, 1'b0);
        end
        clear         = 1'b1;
        s_axis_tdata  = rand_word();
        #1;
        chk("clr_tready", 64'(s_axis_tready), 64'd0);
        tick(1'b0, 0, '0, 1'b1);
        clear         = 1'b0;
        s_axis_tvalid = 1'b0;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(load_done), 64'd0);
        chk("clr_ovf", 64'(ovf_err), 64'd0);
        chk("clr_tready_after", 64'(s_axis_tready), 64'd0);
        tick(1'b0, 0, '0, 1'b0);
        chk("clr_no_done", 64'(load_done), 64'd0);
        chk("clr_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        load_start    = 1'b0;
        load_base     = '0;
        clear         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rd_en         = '0;
        rd_add        = '0;

        do_reset();
        rd_en  = '1;
        rd_add = {AW'(3), AW'(2), AW'(1), AW'(0)};
        tick(1'b0, 0, '0, 1'b0);

        burst(5, 3);
        sweep();

        burst(int'(DEPTH) - 2, 4);
        sweep();

        burst(62, 2);
        sweep();

        clear_mid(20);
        sweep();
        burst(20, 5);

        // Entry 9 holds W, then a later burst overwrites it while port 0 snoops it.
        burst(9, 1);
        burst(8, 4);
        sweep();

        for (int r = 0; r < 12; r++) begin
            burst($urandom_range(0, 63), $urandom_range(1, 8));
        end
        sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
